stream_downsize: RTL

Width converter that splits each wide stream beat (`T_DATA_RATIO` lanes of `T_DATA_WIDTH` bits) into a sequence of narrow beats, one per kept lane, lane 0 first. It sits directly downstream of `stream_upsize` and is its inverse: it consumes the `data`/`keep`/`last` beats that `stream_upsize` produces and restores the original narrow stream. Both sides use a valid/ready handshake, and the block sustains one narrow beat per cycle.

---
 rtl/stream_pkg.sv | 26 ++
 rtl/lane_prio_enc.sv | 27 ++
 rtl/stream_downsize.sv | 116 +++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// ============================================================================
// Module : stream_pkg
// Brief  : Shared types, FSM encodings and lane helpers for the stream width converters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package stream_pkg;

  localparam int c_MAX_LANES = 32;

  localparam int       c_ST_W    = 1;
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_SEND = 1'b1;

  // Index of the lowest set bit, 0 when the mask is empty.
  function automatic int unsigned lowest_set(input logic [c_MAX_LANES-1:0] mask);
    lowest_set = 0;
    for (int i = c_MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = i;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_prio_enc.sv
// ============================================================================
// Module : lane_prio_enc
// Brief  : Combinational priority encoder: lane mask -> lowest set index + found flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lane_prio_enc
  import stream_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  logic [c_MAX_LANES-1:0] w_mask_ext;

  assign w_mask_ext = c_MAX_LANES'(i_mask);
  assign o_idx      = IDX_W'(lowest_set(w_mask_ext));
  assign o_found    = |i_mask;

endmodule

`default_nettype wire

// File: rtl/stream_downsize.sv
// ============================================================================
// Module : stream_downsize
// Brief  : Splits each wide beat into one narrow beat per kept lane, lane 0 first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] s_data_i,
  input  logic [T_DATA_RATIO-1:0]              s_keep_i,
  input  logic                                 s_last_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  output logic [T_DATA_WIDTH-1:0]              m_data_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i
);

  localparam int c_IDX_W = $clog2(T_DATA_RATIO);
  typedef logic [c_IDX_W-1:0] lane_idx_t;

  logic [c_ST_W-1:0]                    r_state;
  logic [c_ST_W-1:0]                    w_state_nxt;
  logic [T_DATA_WIDTH*T_DATA_RATIO-1:0] r_buf_data;
  logic [T_DATA_RATIO-1:0]              r_rem_mask;
  logic                                 r_buf_last;
  logic [T_DATA_WIDTH-1:0]              r_m_data;
  logic                                 r_m_last;
  logic                                 w_m_valid;

  lane_idx_t                            w_keep_idx;
  lane_idx_t                            w_rem_idx;
  logic                                 w_keep_found;
  logic                                 w_rem_found;
  logic [T_DATA_RATIO-1:0]              w_keep_rest;
  logic [T_DATA_RATIO-1:0]              w_rem_rest;
  logic                                 w_s_hs;
  logic                                 w_m_hs;
  logic                                 w_load;

  lane_prio_enc #(.N(T_DATA_RATIO), .IDX_W(c_IDX_W)) u_keep_enc (
    .i_mask  (s_keep_i),
    .o_idx   (w_keep_idx),
    .o_found (w_keep_found)
  );

  lane_prio_enc #(.N(T_DATA_RATIO), .IDX_W(c_IDX_W)) u_rem_enc (
    .i_mask  (r_rem_mask),
    .o_idx   (w_rem_idx),
    .o_found (w_rem_found)
  );

  assign w_keep_rest = s_keep_i   & ~({{(T_DATA_RATIO-1){1'b0}}, 1'b1} << w_keep_idx);
  assign w_rem_rest  = r_rem_mask & ~({{(T_DATA_RATIO-1){1'b0}}, 1'b1} << w_rem_idx);

  // Ready looks through the output stage only once the buffered word is fully drained.
  assign s_ready_o = rst_n & (~w_m_valid | (m_ready_i & ~w_rem_found));
  assign w_s_hs    = s_valid_i & s_ready_o;
  assign w_m_hs    = w_m_valid & m_ready_i;
  assign w_load    = w_s_hs & w_keep_found;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_load) w_state_nxt = c_ST_SEND;
      c_ST_SEND: if (w_m_hs && !w_rem_found && !w_load) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_m_valid = (r_state == c_ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_data <= '0;
      r_rem_mask <= '0;
      r_buf_last <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
    end else if (w_load) begin
      r_buf_data <= s_data_i;
      r_rem_mask <= w_keep_rest;
      r_buf_last <= s_last_i;
      r_m_data   <= s_data_i[w_keep_idx*T_DATA_WIDTH +: T_DATA_WIDTH];
      r_m_last   <= s_last_i & ~(|w_keep_rest);
    end else if (w_m_hs && w_rem_found) begin
      r_rem_mask <= w_rem_rest;
      r_m_data   <= r_buf_data[w_rem_idx*T_DATA_WIDTH +: T_DATA_WIDTH];
      r_m_last   <= r_buf_last & ~(|w_rem_rest);
    end else if (w_m_hs) begin
      r_m_last   <= 1'b0;
    end
  end

  assign m_data_o  = r_m_data;
  assign m_last_o  = r_m_last;
  assign m_valid_o = w_m_valid;

endmodule

`default_nettype wire
